// File: rtl/key_event_pkg.sv
// ============================================================================
// key_event_pkg -- shared types and timing defaults for the key-event front end
// Rev 1.0
// ============================================================================
`default_nettype none

package key_event_pkg;

  typedef enum logic [1:0] {
    KS_IDLE       = 2'd0,
    KS_DB_PRESS   = 2'd1,
    KS_HELD       = 2'd2,
    KS_DB_RELEASE = 2'd3
  } key_state_t;

  // Defaults assume a 50 MHz clock: 10 ms debounce, 0.5 s delay, 125 ms period
  localparam int unsigned KEY_DEBOUNCE_DEFAULT      = 500000;
  localparam int unsigned KEY_REPEAT_DELAY_DEFAULT  = 25000000;
  localparam int unsigned KEY_REPEAT_PERIOD_DEFAULT = 6250000;

  localparam int KEY_CNT_W = 32;

  function automatic logic [KEY_CNT_W-1:0] sat_inc(input logic [KEY_CNT_W-1:0] v);
    return (v == '1) ? v : v + KEY_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_gen_if.sv
// ============================================================================
// key_event_gen_if -- raw keys in, clean press/release/held/repeat events out
// Rev 1.0
// ============================================================================
`default_nettype none

interface key_event_gen_if #(
  parameter int unsigned NUM_KEYS = 3
);

  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] PRESSED;
  logic [NUM_KEYS-1:0] RELEASED;
  logic [NUM_KEYS-1:0] HELD;
  logic [NUM_KEYS-1:0] REPEAT;

  modport master (
    input  KEY,
    output PRESSED,
    output RELEASED,
    output HELD,
    output REPEAT
  );

  modport slave (
    output KEY,
    input  PRESSED,
    input  RELEASED,
    input  HELD,
    input  REPEAT
  );

endinterface

`default_nettype wire

// File: rtl/key_channel.sv
// ============================================================================
// key_channel -- one key: 2-flop synchronizer, debounce FSM, repeat timer
// Auto-repeat built only when KEY_AUTOREPEAT_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module key_channel
  import key_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic pressed,
  output logic released,
  output logic held,
  output logic rpt
);

  localparam logic [KEY_CNT_W-1:0] c_db_last = KEY_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           r_sync;
  logic                 w_down;
  key_state_t           r_state;
  key_state_t           w_state_nxt;
  logic [KEY_CNT_W-1:0] r_cnt;
  logic [KEY_CNT_W-1:0] w_cnt_nxt;
  logic                 r_pressed;
  logic                 r_released;
  logic                 r_held;
  logic                 w_pressed_nxt;
  logic                 w_released_nxt;
  logic                 w_held_nxt;

  // KEY is active-low; invert on entry so everything downstream is active-high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], ~key_raw};
    end
  end

  assign w_down = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= KS_IDLE;
      r_cnt      <= '0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pressed  <= w_pressed_nxt;
      r_released <= w_released_nxt;
      r_held     <= w_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pressed_nxt  = 1'b0;
    w_released_nxt = 1'b0;
    case (r_state)
      KS_IDLE: begin
        w_cnt_nxt = '0;
        if (w_down) begin
          w_state_nxt = KS_DB_PRESS;
        end
      end
      KS_DB_PRESS: begin
        if (!w_down) begin
          w_state_nxt = KS_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_db_last) begin
          w_state_nxt   = KS_HELD;
          w_cnt_nxt     = '0;
          w_pressed_nxt = 1'b1;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      KS_HELD: begin
        w_cnt_nxt = '0;
        if (!w_down) begin
          w_state_nxt = KS_DB_RELEASE;
        end
      end
      KS_DB_RELEASE: begin
        if (w_down) begin
          w_state_nxt = KS_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_db_last) begin
          w_state_nxt    = KS_IDLE;
          w_cnt_nxt      = '0;
          w_released_nxt = 1'b1;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      default: begin
        w_state_nxt = KS_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // The key stays logically down while a release is still being debounced
    w_held_nxt = (w_state_nxt == KS_HELD) || (w_state_nxt == KS_DB_RELEASE);
  end

  assign pressed  = r_pressed;
  assign released = r_released;
  assign held     = r_held;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [KEY_CNT_W-1:0] c_rpt_first = KEY_CNT_W'(REPEAT_DELAY - 1);
  localparam logic [KEY_CNT_W-1:0] c_rpt_next  = KEY_CNT_W'(REPEAT_PERIOD - 1);

  logic [KEY_CNT_W-1:0] r_rpt_left;
  logic                 r_rpt;

  // Cycles remaining until the next pulse; (re)armed on every entry into HELD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rpt_left <= '0;
      r_rpt      <= 1'b0;
    end else begin
      r_rpt <= 1'b0;
      if (w_state_nxt != KS_HELD) begin
        r_rpt_left <= '0;
      end else if (r_state != KS_HELD) begin
        r_rpt_left <= c_rpt_first;
      end else if (r_rpt_left == '0) begin
        r_rpt      <= 1'b1;
        r_rpt_left <= c_rpt_next;
      end else begin
        r_rpt_left <= r_rpt_left - KEY_CNT_W'(1);
      end
    end
  end

  assign rpt = r_rpt;
`else
  // Repeat timing is irrelevant without the timer; fold it away explicitly
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rpt            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/key_event_gen.sv
// ============================================================================
// key_event_gen -- NUM_KEYS independent debounced key channels
// REPEAT is driven only when KEY_AUTOREPEAT_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module key_event_gen
  import key_event_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  key_event_gen_if.master  kif
);

  logic [NUM_KEYS-1:0] w_pressed;
  logic [NUM_KEYS-1:0] w_released;
  logic [NUM_KEYS-1:0] w_held;
  logic [NUM_KEYS-1:0] w_repeat;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .clk      (CLOCK_50),
      .rst      (RESET),
      .key_raw  (kif.KEY[g]),
      .pressed  (w_pressed[g]),
      .released (w_released[g]),
      .held     (w_held[g]),
      .rpt      (w_repeat[g])
    );
  end

  assign kif.PRESSED  = w_pressed;
  assign kif.RELEASED = w_released;
  assign kif.HELD     = w_held;
  assign kif.REPEAT   = w_repeat;

endmodule

`default_nettype wire

// File: doc/key_event_gen.md
# key_event_gen

Front-end conditioner for the board push-buttons: synchronizes and debounces the raw active-low `KEY` inputs and delivers clean single-cycle press/release events, a held level, and an optional auto-repeat pulse. It is the producing side of the key-event interface that flasher and speed-control logic consume. Those consumers no longer need their own ad-hoc clicked/unclicked tracking.

## Interface
Parameters:
- `NUM_KEYS`, 3: number of independent key channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Legal range is ≥ 1.
- `REPEAT_DELAY`, 25000000: cycles from `PRESSED` to the first `REPEAT` (0.5 s).
- `REPEAT_PERIOD`, 6250000: cycles between subsequent `REPEAT` pulses (125 ms).

Ports:
- `CLOCK_50`  in  1: sole clock; all logic on the rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `KEY`  in  NUM_KEYS: raw asynchronous buttons, active-low (0 = pushed).
- `PRESSED`  out  NUM_KEYS: one-cycle pulse per accepted press.
- `RELEASED`  out  NUM_KEYS: one-cycle pulse per accepted release.
- `HELD`  out  NUM_KEYS: level, high while the key is logically down.
- `REPEAT`  out  NUM_KEYS: one-cycle auto-repeat pulse. This port is always present.

## Operation
- Each channel is fully independent. Simultaneous activity on several keys produces simultaneous, unrelated events.
- Synchronizer: two flops per key, inverted to active-high `down`. The synchronizer resets to 0 (released).
- Each channel has a per-key FSM with a down-counter-free event counter `cnt`. The counter is 32 bits wide and saturates internally, so it never wraps.
  - `IDLE`: `cnt`=0. If `down` is set, go to `DB_PRESS` with `cnt`=0.
  - `DB_PRESS`: if `down`=0, return to `IDLE` with no event. If `cnt`==DEBOUNCE_CYCLES-1, go to `HELD` and pulse `PRESSED`. Otherwise increment `cnt`.
  - `HELD`: if `down`=0, go to `DB_RELEASE` with `cnt`=0.
  - `DB_RELEASE`: if `down`=1, return to `HELD` with no event; the repeat timer restarts at `REPEAT_DELAY`. If `cnt`==DEBOUNCE_CYCLES-1, go to `IDLE` and pulse `RELEASED`. Otherwise increment `cnt`.
- `HELD` output is 1 in the `HELD` and `DB_RELEASE` states, 0 in `IDLE` and `DB_PRESS`.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no event in either direction.
- `PRESSED` and `RELEASED` strictly alternate per key, starting with `PRESSED`.

## Timing
- All outputs are registered. Reset value of every output is 0, and every FSM resets to `IDLE`.
- Press latency: with `KEY` stable low from edge 1, `PRESSED` is high for exactly the cycle after edge `DEBOUNCE_CYCLES`+3. `HELD` rises on the same edge.
- Release latency is symmetric: `RELEASED` is high after edge `DEBOUNCE_CYCLES`+3 counted from the first edge sampling `KEY` high. `HELD` falls on the same edge.
- `RESET` mid-operation: the channel returns to `IDLE` with no `RELEASED` emitted.
- A key held through reset is treated as a fresh press: `PRESSED` follows `DEBOUNCE_CYCLES`+3 edges after `RESET` deasserts.
- `PRESSED` and `RELEASED` are never high in the same cycle for one key.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - While in `HELD` (not `DB_RELEASE`), a repeat timer runs.
  - The first `REPEAT` pulse comes `REPEAT_DELAY` cycles after the `PRESSED` cycle, then one every `REPEAT_PERIOD` cycles.
  - The timer is cleared on leaving `HELD`.
  - `REPEAT` is never asserted in the `PRESSED` cycle.
- `KEY_AUTOREPEAT_EN` undefined: the repeat timers are not built, and `REPEAT` is tied to 0.

## Structure
- Package `key_event_pkg`:
  - State typedef `key_state_t` with values `KS_IDLE`, `KS_DB_PRESS`, `KS_HELD`, `KS_DB_RELEASE`.
  - Default timing constants `KEY_DEBOUNCE_DEFAULT`, `KEY_REPEAT_DELAY_DEFAULT`, `KEY_REPEAT_PERIOD_DEFAULT`.
  - Counter width constant `KEY_CNT_W` = 32.
- Sub-module `key_channel`: one key's synchronizer, FSM, debounce counter and repeat timer. The top instantiates `NUM_KEYS` copies in a generate loop.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- **Clean press:** `KEY[0]` low from edge 1 → `PRESSED[0]` high for one cycle after edge 7, `HELD[0]` high from edge 7. Other keys stay 0.
- **Bounce:** `KEY[1]` low for 3 cycles, high 2, then low steady → no event during the bounce. A single `PRESSED[1]` 7 edges after the steady low begins.
- **Release with glitch:** while held, `KEY[0]` high for 2 cycles then low → no `RELEASED` and `HELD` stays 1. A later steady high → one `RELEASED[0]` after 7 edges and `HELD` falls.
- **Auto-repeat** (`KEY_AUTOREPEAT_EN` defined): hold `KEY[2]` → `REPEAT[2]` pulses 10, 13, 16 cycles after `PRESSED[2]`. With the macro undefined, `REPEAT` stays 0.
- **Reset mid-hold:** `RESET` for 1 cycle while `HELD[0]`=1 and `KEY[0]` still low → all outputs 0 next cycle, no `RELEASED`. `PRESSED[0]` reappears 7 edges after `RESET` deasserts.
- **Simultaneous keys:** all three keys pressed on the same edge → three `PRESSED` bits high in the same cycle, then independent release timing.
